// File: rtl/reg_access_master.sv
// Register-file access master: accepts READ/WRITE/COPY/CLEAR requests, sequences
// single-cycle register-file strobes and returns one response per request.
module reg_access_master #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_src,
    input  logic [ADDR_W-1:0] req_dst,
    input  logic [DATA_W-1:0] req_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic [15:0]       txn_count,
    output logic              rf_rd,
    output logic              rf_wn,
    output logic [ADDR_W-1:0] rf_reg_id,
    output logic [DATA_W-1:0] rf_write_data,
    input  logic [DATA_W-1:0] rf_read_data
);

    localparam int unsigned CNT_W = 16;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_COPY  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR_ISSUE,
        RESP
    } state_t;

    state_t              r_state;
    logic [1:0]          r_op;
    logic [ADDR_W-1:0]   r_dst;
    logic                r_rf_rd;
    logic                r_rf_wn;
    logic [ADDR_W-1:0]   r_rf_reg_id;
    logic [DATA_W-1:0]   r_rf_write_data;
    logic                r_resp_valid;
    logic [DATA_W-1:0]   r_resp_data;
    logic [CNT_W-1:0]    r_txn_count;

    state_t              w_state_nxt;
    logic [1:0]          w_op_nxt;
    logic [ADDR_W-1:0]   w_dst_nxt;
    logic                w_rf_rd_nxt;
    logic                w_rf_wn_nxt;
    logic [ADDR_W-1:0]   w_rf_reg_id_nxt;
    logic [DATA_W-1:0]   w_rf_write_data_nxt;
    logic                w_resp_valid_nxt;
    logic [DATA_W-1:0]   w_resp_data_nxt;
    logic [CNT_W-1:0]    w_txn_count_nxt;

    // State and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_op            <= OP_READ;
            r_dst           <= '0;
            r_rf_rd         <= 1'b0;
            r_rf_wn         <= 1'b0;
            r_rf_reg_id     <= '0;
            r_rf_write_data <= '0;
            r_resp_valid    <= 1'b0;
            r_resp_data     <= '0;
            r_txn_count     <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_op            <= w_op_nxt;
            r_dst           <= w_dst_nxt;
            r_rf_rd         <= w_rf_rd_nxt;
            r_rf_wn         <= w_rf_wn_nxt;
            r_rf_reg_id     <= w_rf_reg_id_nxt;
            r_rf_write_data <= w_rf_write_data_nxt;
            r_resp_valid    <= w_resp_valid_nxt;
            r_resp_data     <= w_resp_data_nxt;
            r_txn_count     <= w_txn_count_nxt;
        end
    end

    // Next-state and next-output logic; strobes default low so each lasts one cycle
    always_comb begin
        w_state_nxt         = r_state;
        w_op_nxt            = r_op;
        w_dst_nxt           = r_dst;
        w_rf_rd_nxt         = 1'b0;
        w_rf_wn_nxt         = 1'b0;
        w_rf_reg_id_nxt     = r_rf_reg_id;
        w_rf_write_data_nxt = r_rf_write_data;
        w_resp_valid_nxt    = r_resp_valid;
        w_resp_data_nxt     = r_resp_data;
        w_txn_count_nxt     = r_txn_count;

        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_op_nxt  = req_op;
                    w_dst_nxt = req_dst;
                    case (req_op)
                        OP_READ, OP_COPY: begin
                            w_state_nxt     = RD_ISSUE;
                            w_rf_rd_nxt     = 1'b1;
                            w_rf_reg_id_nxt = req_src;
                        end
                        OP_WRITE: begin
                            w_state_nxt         = WR_ISSUE;
                            w_rf_wn_nxt         = 1'b1;
                            w_rf_reg_id_nxt     = req_dst;
                            w_rf_write_data_nxt = req_data;
                        end
                        OP_CLEAR: begin
                            w_state_nxt         = WR_ISSUE;
                            w_rf_wn_nxt         = 1'b1;
                            w_rf_reg_id_nxt     = req_dst;
                            w_rf_write_data_nxt = '0;
                        end
                    endcase
                end
            end
            RD_ISSUE: begin
                w_state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                // Read data is valid this cycle; COPY forwards it straight into the write
                if (r_op == OP_COPY) begin
                    w_state_nxt         = WR_ISSUE;
                    w_rf_wn_nxt         = 1'b1;
                    w_rf_reg_id_nxt     = r_dst;
                    w_rf_write_data_nxt = rf_read_data;
                end else begin
                    w_state_nxt      = RESP;
                    w_resp_valid_nxt = 1'b1;
                    w_resp_data_nxt  = rf_read_data;
                end
            end
            WR_ISSUE: begin
                w_state_nxt      = RESP;
                w_resp_valid_nxt = 1'b1;
                w_resp_data_nxt  = r_rf_write_data;
            end
            RESP: begin
                if (resp_ready) begin
                    w_state_nxt      = IDLE;
                    w_resp_valid_nxt = 1'b0;
                    w_txn_count_nxt  = CNT_W'(r_txn_count + CNT_W'(1));
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign req_ready     = (r_state == IDLE);
    assign resp_valid    = r_resp_valid;
    assign resp_data     = r_resp_data;
    assign txn_count     = r_txn_count;
    assign rf_rd         = r_rf_rd;
    assign rf_wn         = r_rf_wn;
    assign rf_reg_id     = r_rf_reg_id;
    assign rf_write_data = r_rf_write_data;

endmodule

// File: tb/tb_reg_access_master.sv
// Bench for reg_access_master: table of requests against a behavioural register file,
// responses checked through a scoreboard queue, plus reset-abort and counter-wrap sequences.
module tb_reg_access_master;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 4;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_COPY  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic          req_valid  = 1'b0;
    logic          resp_ready = 1'b1;
    logic [1:0]    req_op     = 2'b00;
    logic [AW-1:0] req_src    = '0;
    logic [AW-1:0] req_dst    = '0;
    logic [DW-1:0] req_data   = '0;
    logic          req_ready;
    logic          resp_valid;
    logic [DW-1:0] resp_data;
    logic [15:0]   txn_count;
    logic          rf_rd;
    logic          rf_wn;
    logic [AW-1:0] rf_reg_id;
    logic [DW-1:0] rf_write_data;
    logic [DW-1:0] rf_read_data = '0;
    logic [DW-1:0] mem [16] = '{default: '0};

    reg_access_master #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_src       (req_src),
        .req_dst       (req_dst),
        .req_data      (req_data),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_data     (resp_data),
        .txn_count     (txn_count),
        .rf_rd         (rf_rd),
        .rf_wn         (rf_wn),
        .rf_reg_id     (rf_reg_id),
        .rf_write_data (rf_write_data),
        .rf_read_data  (rf_read_data)
    );

    always #5 clk = ~clk;

    // Register file: read data valid the cycle after the sampling edge; not reset
    always @(posedge clk) begin
        if (rf_wn) mem[rf_reg_id] <= rf_write_data;
        if (rf_rd) rf_read_data <= mem[rf_reg_id];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    logic [DW-1:0] sb_q [$];
    int            rd_pulses = 0;
    int            wr_pulses = 0;
    logic [AW-1:0] last_wr_id = '0;
    logic [DW-1:0] last_wr_data = '0;

    // Strobe monitor and scoreboard consumer, sampled on the falling edge
    always @(negedge clk) begin
        if (rf_rd) rd_pulses++;
        if (rf_wn) begin
            wr_pulses++;
            last_wr_id   = rf_reg_id;
            last_wr_data = rf_write_data;
        end
        if (rf_rd && rf_wn) begin
            checks++;
            errors++;
            $display("FAIL strobe_excl actual rd=1 wn=1 expected at most one");
        end
        if (rst_n && resp_valid && resp_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected actual=0x%0h expected no response", resp_data);
            end else begin
                check("sb_resp_data", 32'(resp_data), 32'(sb_q.pop_front()));
            end
        end
    end

    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic [DW-1:0] data;
        logic [DW-1:0] exp;
        int            lat;
        int            hold;
    } vec_t;

    logic [15:0] exp_txn = '0;

    // Issue one request from posedge+1, follow it through handshake and check it
    task automatic do_req(input vec_t v);
        int lat;
        int guard;
        int rd0;
        int wr0;
        int exp_rd;
        int exp_wr;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("req_ready_idle", 32'(req_ready), 32'd1);
        rd0        = rd_pulses;
        wr0        = wr_pulses;
        req_valid  = 1'b1;
        req_op     = v.op;
        req_src    = v.src;
        req_dst    = v.dst;
        req_data   = v.data;
        resp_ready = (v.hold == 0);
        sb_q.push_back(v.exp);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_src   = AW'($urandom);
        req_dst   = AW'($urandom);
        req_data  = DW'($urandom);
        check("req_ready_busy", 32'(req_ready), 32'd0);
        lat = 0;
        while (!resp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(v.lat));
        for (int i = 0; i < v.hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(resp_valid), 32'd1);
            check("hold_data", 32'(resp_data), 32'(v.exp));
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        guard = 0;
        while (resp_valid && guard < 10) begin
            @(posedge clk); #1;
            guard++;
        end
        check("resp_drop", 32'(resp_valid), 32'd0);
        exp_txn = exp_txn + 16'd1;
        check("txn_count", 32'(txn_count), 32'(exp_txn));
        exp_rd = (v.op == OP_READ || v.op == OP_COPY) ? 1 : 0;
        exp_wr = (v.op == OP_READ) ? 0 : 1;
        check("rd_pulses", 32'(rd_pulses - rd0), 32'(exp_rd));
        check("wr_pulses", 32'(wr_pulses - wr0), 32'(exp_wr));
        if (exp_wr == 1) begin
            check("wr_id", 32'(last_wr_id), 32'(v.dst));
            check("wr_data", 32'(last_wr_data), 32'(v.exp));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    vec_t vecs [12];

    initial begin
        int wr0;
        vec_t rv;

        vecs[0]  = '{OP_WRITE, 4'd0, 4'd3, 16'hBEEF, 16'hBEEF, 1, 0};
        vecs[1]  = '{OP_READ,  4'd3, 4'd0, 16'h0000, 16'hBEEF, 2, 0};
        vecs[2]  = '{OP_COPY,  4'd3, 4'd7, 16'h0000, 16'hBEEF, 3, 0};
        vecs[3]  = '{OP_READ,  4'd7, 4'd0, 16'h0000, 16'hBEEF, 2, 0};
        vecs[4]  = '{OP_CLEAR, 4'd0, 4'd7, 16'hA5A5, 16'h0000, 1, 5};
        vecs[5]  = '{OP_READ,  4'd7, 4'd0, 16'h0000, 16'h0000, 2, 0};
        vecs[6]  = '{OP_WRITE, 4'd0, 4'd5, 16'h1234, 16'h1234, 1, 2};
        vecs[7]  = '{OP_COPY,  4'd5, 4'd5, 16'h0000, 16'h1234, 3, 0};
        vecs[8]  = '{OP_READ,  4'd5, 4'd0, 16'h0000, 16'h1234, 2, 0};
        vecs[9]  = '{OP_WRITE, 4'd0, 4'd15, 16'hFFFF, 16'hFFFF, 1, 0};
        vecs[10] = '{OP_COPY,  4'd15, 4'd0, 16'h0000, 16'hFFFF, 3, 1};
        vecs[11] = '{OP_READ,  4'd0, 4'd0, 16'h0000, 16'hFFFF, 2, 0};

        #2;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_data", 32'(resp_data), 32'd0);
        check("rst_txn_count", 32'(txn_count), 32'd0);
        check("rst_rf_strobes", {30'd0, rf_rd, rf_wn}, 32'd0);
        check("rst_rf_reg_id", 32'(rf_reg_id), 32'd0);
        check("rst_rf_wdata", 32'(rf_write_data), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) do_req(vecs[i]);

        // Reset while a COPY sits in RD_WAIT must abort it without touching dst
        wr0       = wr_pulses;
        req_valid = 1'b1;
        req_op    = OP_COPY;
        req_src   = 4'd3;
        req_dst   = 4'd9;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_rf_rd", 32'(rf_rd), 32'd0);
        check("abort_rf_wn", 32'(rf_wn), 32'd0);
        check("abort_resp_valid", 32'(resp_valid), 32'd0);
        check("abort_txn_count", 32'(txn_count), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check("abort_no_write", 32'(wr_pulses - wr0), 32'd0);
        check("abort_dst_mem", 32'(mem[9]), 32'd0);
        rst_n   = 1'b1;
        exp_txn = '0;
        check("release_req_ready", 32'(req_ready), 32'd1);
        rv = '{OP_READ, 4'd9, 4'd0, 16'h0000, 16'h0000, 2, 0};
        do_req(rv);
        rv = '{OP_READ, 4'd3, 4'd0, 16'h0000, 16'hBEEF, 2, 0};
        do_req(rv);

        // Counter wrap: start from just below the top rather than walking 65k requests
        force dut.r_txn_count = 16'hFFFE;
        #1;
        release dut.r_txn_count;
        @(posedge clk); #1;
        check("preload_txn", 32'(txn_count), 32'h0000FFFE);
        exp_txn = 16'hFFFE;
        rv = '{OP_WRITE, 4'd0, 4'd2, 16'h0F0F, 16'h0F0F, 1, 0};
        do_req(rv);
        rv = '{OP_WRITE, 4'd0, 4'd2, 16'hF0F0, 16'hF0F0, 1, 0};
        do_req(rv);
        check("wrap_txn_zero", 32'(txn_count), 32'd0);

        repeat (2) @(posedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_access_master.md
REG_ACCESS_MASTER -- requirements
Module: reg_access_master

Interface
REQ-001 Parameter DATA_W, default 16: register data width.
REQ-002 Parameter ADDR_W, default 4: register index width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  block can accept a request.
REQ-007 req_op  input  2  00 READ, 01 WRITE, 10 COPY, 11 CLEAR.
REQ-008 req_src  input  ADDR_W  source register index (READ, COPY).
REQ-009 req_dst  input  ADDR_W  destination register index (WRITE, COPY, CLEAR).
REQ-010 req_data  input  DATA_W  write data (WRITE only).
REQ-011 resp_valid  output  1  response present.
REQ-012 resp_ready  input  1  consumer accepts response.
REQ-013 resp_data  output  DATA_W  read/copied/written value.
REQ-014 txn_count  output  16  count of completed response handshakes.
REQ-015 rf_rd  output  1  register-file read strobe.
REQ-016 rf_wn  output  1  register-file write strobe.
REQ-017 rf_reg_id  output  ADDR_W  register-file index.
REQ-018 rf_write_data  output  DATA_W  register-file write data.
REQ-019 rf_read_data  input  DATA_W  register-file read data, valid the cycle after the posedge that sampled rf_rd=1.

Function
REQ-020 All outputs SHALL be registered except req_ready, which SHALL equal (state==IDLE).
REQ-021 FSM states SHALL be IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESP.
REQ-022 Acceptance SHALL occur on a posedge with req_valid=1 and req_ready=1; all req_* fields SHALL be latched at that edge and ignored afterwards.
REQ-023 On acceptance: READ/COPY -> RD_ISSUE with rf_rd=1, rf_reg_id=req_src; WRITE -> WR_ISSUE with rf_wn=1, rf_reg_id=req_dst, rf_write_data=req_data; CLEAR -> WR_ISSUE with rf_wn=1, rf_reg_id=req_dst, rf_write_data=0.
REQ-024 Each strobe SHALL be high for exactly one cycle; rf_rd and rf_wn SHALL never be 1 simultaneously.
REQ-025 RD_ISSUE SHALL always advance to RD_WAIT with rf_rd=0.
REQ-026 RD_WAIT SHALL capture rf_read_data into an internal data register; READ -> RESP with resp_data=captured value; COPY -> WR_ISSUE with rf_wn=1, rf_reg_id=latched dst, rf_write_data=captured value.
REQ-027 WR_ISSUE SHALL advance to RESP with rf_wn=0, resp_data=value written.
REQ-028 Latency from acceptance edge to resp_valid=1: WRITE/CLEAR 1 cycle, READ 2 cycles, COPY 3 cycles.
REQ-029 In RESP, resp_valid and resp_data SHALL hold stable until a posedge with resp_ready=1, then resp_valid=0 and state=IDLE.
REQ-030 No new request SHALL be accepted in the same cycle as a response handshake; minimum request spacing is latency+1 cycles.
REQ-031 txn_count SHALL increment by 1 on each response handshake and wrap 0xFFFF -> 0x0000.
REQ-032 COPY with src==dst SHALL perform both accesses normally and return the register value.
REQ-033 resp_ready held high before RESP SHALL have no effect.

Reset
REQ-034 rst_n=0 SHALL immediately force state=IDLE, rf_rd=0, rf_wn=0, rf_reg_id=0, rf_write_data=0, resp_valid=0, resp_data=0, txn_count=0.
REQ-035 Reset mid-operation SHALL abort the transaction with no response; register-file contents are not reset.
REQ-036 First acceptance SHALL be possible on the first posedge after rst_n deasserts.

Verification
REQ-037 WRITE dst=3 data=0xBEEF, resp_ready=1 -> rf_wn pulse 1 cycle, rf_reg_id=3, resp_valid 1 cycle after accept, resp_data=0xBEEF, txn_count=1.
REQ-038 READ src=3 after above -> rf_rd pulse, resp_valid 2 cycles after accept, resp_data=0xBEEF.
REQ-039 COPY src=3 dst=7 then READ src=7 -> rf_rd then rf_wn at index 7, copy resp_data=0xBEEF at 3 cycles, read returns 0xBEEF.
REQ-040 CLEAR dst=7 with resp_ready=0 for 5 cycles -> resp_valid/resp_data=0x0000 stable, req_ready=0 throughout; READ src=7 returns 0x0000.
REQ-041 rst_n asserted during RD_WAIT of COPY -> rf_rd/rf_wn=0 at once, no write to dst, resp_valid=0, txn_count=0, req_ready=1 after release.
REQ-042 Preload txn_count to 0xFFFF via 65535 WRITEs, one more -> txn_count=0x0000.
